// File: rtl/dmem_bus_if.sv
// Data-memory bus interface: turns the single-cycle datapath's load/store
// request into a req/ack bus transaction, stalls the core while it runs and
// returns aligned, extended load data. Flags illegal accesses, bus errors
// and timeouts with one-cycle pulses.
//
// Bus handshake: bus_req is held high together with stable bus_we, bus_addr,
// bus_wdata and bus_be for every BUSY cycle; the transfer completes in the
// cycle bus_ack is sampled high, and bus_err/bus_rdata are only meaningful
// in that cycle. Acks seen outside BUSY are ignored.
module dmem_bus_if #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misalign,
  output logic        buserr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_in;
  logic        we_in;
  logic        illegal;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;

  // Decode the incoming request: legality, byte enables, replicated store data
  always_comb begin
    req_in   = memread | memwrite;
    we_in    = memwrite;
    illegal  = 1'b0;
    be_in    = 4'b1111;
    wdata_in = writedata;
    if (we_in) begin
      case (funct3)
        3'b000: begin
          be_in    = 4'b0001 << addr[1:0];
          wdata_in = {4{writedata[7:0]}};
        end
        3'b001: begin
          illegal  = addr[0];
          be_in    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_in = {2{writedata[15:0]}};
        end
        3'b010:  illegal = (addr[1:0] != 2'b00);
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b100: illegal = 1'b0;
        3'b001, 3'b101: illegal = addr[0];
        3'b010:         illegal = (addr[1:0] != 2'b00);
        default:        illegal = 1'b1;
      endcase
    end
  end

  // State and capture registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      f3_q    <= 3'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept legal requests, wait for ack or timeout, respond
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_in && !illegal) begin
          state_d = S_BUSY;
          cnt_d   = 8'd0;
          addr_d  = addr;
          wdata_d = wdata_in;
          be_d    = be_in;
          f3_d    = funct3;
          we_d    = we_in;
          err_d   = 1'b0;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_ack) begin
          state_d = S_RESP;
          rdata_d = bus_rdata;
          err_d   = bus_err;
        end else if (cnt_d == TIMEOUT_C) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Select and extend the load lane from the captured read data
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = rdata_q[7:0];
      2'd1:    lane_b = rdata_q[15:8];
      2'd2:    lane_b = rdata_q[23:16];
      default: lane_b = rdata_q[31:24];
    endcase
    lane_h = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_val = {24'd0, lane_b};
      3'b101:  load_val = {16'd0, lane_h};
      default: load_val = rdata_q;
    endcase
  end

  // Outputs per state; everything is forced low while reset is held
  always_comb begin
    readdata  = 32'd0;
    stall     = 1'b0;
    misalign  = 1'b0;
    buserr    = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    bus_be    = 4'd0;
    dbg_state = state_q;
    if (reset) begin
      case (state_q)
        S_IDLE: begin
          stall    = req_in && !illegal;
          misalign = req_in && illegal;
        end
        S_BUSY: begin
          stall     = 1'b1;
          bus_req   = 1'b1;
          bus_we    = we_q;
          bus_addr  = {addr_q[31:2], 2'b00};
          bus_wdata = wdata_q;
          bus_be    = be_q;
        end
        S_RESP: begin
          buserr   = err_q;
          readdata = (!we_q && !err_q) ? load_val : 32'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_if.sv
// Testbench for dmem_bus_if (TIMEOUT = 4). Inputs change on the falling
// edge, outputs are sampled 1 ns later.
module tb_dmem_bus_if;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        stall;
  logic        misalign;
  logic        buserr;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  dmem_bus_if #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .funct3(funct3), .addr(addr), .writedata(writedata), .readdata(readdata),
    .stall(stall), .misalign(misalign), .buserr(buserr), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ack(bus_ack), .bus_err(bus_err),
    .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * a[1:0])) & 32'hFF;
    h = (rd >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic we, input logic [2:0] f3,
                                        input logic [31:0] a);
    if (!we) return 4'hF;
    case (f3)
      3'b000:  return 4'(1 << a[1:0]);
      3'b001:  return 4'(3 << (2 * a[1]));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000:  return (wd & 32'hFF) * 32'h01010101;
      3'b001:  return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  // ---------------- driver: one complete legal access ----------------
  // ack_at = BUSY cycle on which bus_ack is driven; 0 = never (timeout)
  task automatic do_access(input logic we, input logic both, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                           input logic err, input logic [31:0] rd, input string tag);
    int n;
    int stall_cnt;
    int req_cnt;
    int exp_stall;
    logic done;
    logic exp_err;
    logic [31:0] exp_rd;
    exp_err = (ack_at == 0) || err;
    exp_q.push_back((we || exp_err) ? 32'd0 : ref_load(f3, a, rd));
    exp_stall = ((ack_at == 0) ? TO : ack_at) + 1;
    @(negedge clk);
    memread = !we || both; memwrite = we; funct3 = f3; addr = a; writedata = wd;
    bus_ack = 1'b0; bus_err = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1 || bus_req !== 1'b0 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: stall=%b req=%b mis=%b want 1 0 0", tag, stall, bus_req, misalign);
    end
    stall_cnt = (stall === 1'b1) ? 1 : 0;
    req_cnt = 0;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      n++;
      #1;
      if (stall === 1'b1) stall_cnt++;
      if (bus_req === 1'b1) req_cnt++;
      checks++;
      if (bus_req !== 1'b1 || stall !== 1'b1 || bus_we !== we ||
          bus_addr !== {a[31:2], 2'b00} || bus_be !== ref_be(we, f3, a) ||
          readdata !== 32'd0) begin
        errors++;
        $display("FAIL %s busy%0d: req=%b stall=%b we=%b addr=%h be=%b rd=%h want 1 1 %b %h %b 0",
                 tag, n, bus_req, stall, bus_we, bus_addr, bus_be, readdata,
                 we, {a[31:2], 2'b00}, ref_be(we, f3, a));
      end
      if (we) begin
        checks++;
        if (bus_wdata !== ref_wdata(f3, wd)) begin
          errors++;
          $display("FAIL %s wdata: got %h want %h", tag, bus_wdata, ref_wdata(f3, wd));
        end
      end
      if (n == ack_at) begin
        bus_ack = 1'b1; bus_err = err; bus_rdata = rd; done = 1'b1;
      end else begin
        bus_ack = 1'b0; bus_rdata = $urandom;
        if (n >= TO) done = 1'b1;
      end
    end
    @(negedge clk);
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
    #1;
    exp_rd = exp_q.pop_front();
    checks++;
    if (stall !== 1'b0 || bus_req !== 1'b0 || readdata !== exp_rd ||
        buserr !== exp_err || misalign !== 1'b0) begin
      errors++;
      $display("FAIL %s resp: stall=%b req=%b rd=%h err=%b mis=%b want 0 0 %h %b 0",
               tag, stall, bus_req, readdata, buserr, misalign, exp_rd, exp_err);
    end
    checks++;
    if (stall_cnt != exp_stall || req_cnt != exp_stall - 1) begin
      errors++;
      $display("FAIL %s cycles: stall=%0d req=%0d want %0d %0d",
               tag, stall_cnt, req_cnt, exp_stall, exp_stall - 1);
    end
    memread = 1'b0; memwrite = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (buserr !== 1'b0 || readdata !== 32'd0 || stall !== 1'b0 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL %s after: err=%b rd=%h stall=%b req=%b want all 0",
               tag, buserr, readdata, stall, bus_req);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    memread = 1'b1; funct3 = 3'b010; addr = 32'h40;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b0 || bus_req !== 1'b0 || misalign !== 1'b0 || buserr !== 1'b0 ||
        readdata !== 32'd0 || bus_be !== 4'd0 || bus_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset: stall=%b req=%b mis=%b err=%b rd=%h be=%b addr=%h want all 0",
               stall, bus_req, misalign, buserr, readdata, bus_be, bus_addr);
    end
    memread = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b0 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: stall=%b req=%b want 0 0", stall, bus_req);
    end
  endtask

  task automatic test_directed();
    do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 3, 1'b0, 32'h0, "sw_late");
    do_access(1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 1, 1'b0, 32'h80FF1234, "lb");
    do_access(1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 2, 1'b0, 32'h80FF1234, "lbu");
    do_access(1'b0, 1'b0, 3'b001, 32'h102, 32'h0, 1, 1'b0, 32'h80FF1234, "lh");
    do_access(1'b0, 1'b0, 3'b101, 32'h100, 32'h0, 4, 1'b0, 32'h80FF9234, "lhu");
    do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0000ABCD, 2, 1'b0, 32'h0, "sh");
    do_access(1'b1, 1'b0, 3'b000, 32'h101, 32'h123456A5, 1, 1'b0, 32'h0, "sb");
    do_access(1'b1, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 2, 1'b0, 32'h0, "both_is_write");
  endtask

  task automatic test_illegal_one(input logic we, input logic [2:0] f3,
                                  input logic [31:0] a, input string tag);
    @(negedge clk);
    memread = !we; memwrite = we; funct3 = f3; addr = a;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (misalign !== 1'b1 || stall !== 1'b0 || bus_req !== 1'b0 || readdata !== 32'd0) begin
        errors++;
        $display("FAIL %s cyc%0d: mis=%b stall=%b req=%b rd=%h want 1 0 0 0",
                 tag, i, misalign, stall, bus_req, readdata);
      end
      @(negedge clk);
    end
    memread = 1'b0; memwrite = 1'b0;
    #1;
    checks++;
    if (misalign !== 1'b0 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL %s clear: mis=%b req=%b want 0 0", tag, misalign, bus_req);
    end
  endtask

  task automatic test_illegal();
    test_illegal_one(1'b0, 3'b010, 32'h102, "lw_mis");
    test_illegal_one(1'b0, 3'b011, 32'h100, "ld_f3_011");
    test_illegal_one(1'b0, 3'b110, 32'h100, "ld_f3_110");
    test_illegal_one(1'b0, 3'b101, 32'h101, "lhu_mis");
    test_illegal_one(1'b1, 3'b001, 32'h103, "sh_mis");
    test_illegal_one(1'b1, 3'b100, 32'h100, "st_f3_100");
    test_illegal_one(1'b1, 3'b010, 32'h101, "sw_mis");
  endtask

  task automatic test_timeout_error();
    do_access(1'b0, 1'b0, 3'b010, 32'h300, 32'h0, 0, 1'b0, 32'h0, "timeout_ld");
    do_access(1'b1, 1'b0, 3'b010, 32'h304, 32'h11112222, 0, 1'b0, 32'h0, "timeout_st");
    do_access(1'b0, 1'b0, 3'b010, 32'h308, 32'h0, 2, 1'b1, 32'h55AA55AA, "buserr_ld");
  endtask

  task automatic test_ignored_ack();
    @(negedge clk);
    bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_ack = 1'b0; bus_err = 1'b0;
    #1;
    checks++;
    if (buserr !== 1'b0 || stall !== 1'b0 || bus_req !== 1'b0 || readdata !== 32'd0) begin
      errors++;
      $display("FAIL idle_ack: err=%b stall=%b req=%b rd=%h want all 0",
               buserr, stall, bus_req, readdata);
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    memread = 1'b1; memwrite = 1'b0; funct3 = 3'b010; addr = 32'h3C0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus_req !== 1'b1) begin
      errors++;
      $display("FAIL midop_pre: req=%b want 1", bus_req);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (bus_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL midop_async: req=%b stall=%b want 0 0", bus_req, stall);
    end
    memread = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    do_access(1'b0, 1'b0, 3'b010, 32'h200, 32'h0, 2, 1'b0, 32'h13579BDF, "lw_after_reset");
  endtask

  task automatic test_random();
    logic [2:0] ld_f3[5];
    logic [2:0] st_f3[3];
    logic we, both, err;
    logic [2:0] f3;
    logic [31:0] a;
    int ack_at;
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_f3 = '{3'b000, 3'b001, 3'b010};
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      both = we && ($urandom_range(0, 3) == 0);
      f3 = we ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
      a = $urandom;
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      ack_at = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO);
      err = ($urandom_range(0, 9) == 0);
      do_access(we, both, f3, a, $urandom, ack_at, err, $urandom, "rand");
    end
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_timeout_error();
    test_ignored_ack();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_bus_if.md
Name: dmem_bus_if

Overview:
- Data-memory interface stage directly downstream of the single-cycle datapath.
- Consumes the datapath's load/store request (ALU result as address, store data, size/sign) and runs a req/ack transaction on a multi-cycle data bus.
- Stalls the core until the transaction completes, then returns aligned, sign- or zero-extended load data to the datapath's readdata input.
- Generates store byte enables and lane-replicated write data, and flags misaligned or illegal accesses, bus errors and timeouts.

Parameters:
- TIMEOUT, 255: maximum BUSY cycles without bus_ack before the access is aborted. Legal range 1..255; the counter is 8 bits.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset; logic is held in reset while reset=0
- memread  in  1  load request from decoder, level
- memwrite  in  1  store request from decoder, level
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only)
- addr  in  32  byte address (datapath aluresult)
- writedata  in  32  store data (datapath writedata)
- readdata  out  32  aligned, extended load data to datapath
- stall  out  1  freeze PC/regfile write while high
- misalign  out  1  one-cycle flag: misaligned or illegal access
- buserr  out  1  one-cycle flag: bus error or timeout
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {addr[31:2],2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables
- bus_ack  in  1  transaction complete
- bus_err  in  1  error, qualified by bus_ack
- bus_rdata  in  32  read data, qualified by bus_ack

Behaviour:
- Reset (async, reset=0): state IDLE, timeout counter 0. All outputs 0, including readdata; bus_req drops immediately, even mid-transaction.
- FSM states: IDLE, BUSY, RESP.
- IDLE, no request (memread=memwrite=0): stall=0, bus_req=0.
- IDLE, request present and legal: stall=1 combinationally. At the clock edge, capture addr/writedata/funct3/we and move to BUSY.
- If memread and memwrite are both high, the access is a write.
- Illegal access is any of:
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0;
  - load funct3 in {011,110,111};
  - store funct3 not in {000,001,010}.
- Illegal access in IDLE: no bus transaction, stall=0, misalign=1 for that cycle, readdata=0, state stays IDLE.
- BUSY:
  - bus_req=1, stall=1; bus_we/bus_addr/bus_wdata/bus_be driven from captured registers, stable until exit.
  - Counter increments each BUSY cycle.
  - On bus_ack: capture bus_rdata and bus_err, go to RESP.
  - If the counter reaches TIMEOUT without ack: go to RESP with the error flag set, bus_req deasserted.
- RESP (exactly one cycle): stall=0 and bus_req=0. Then unconditionally return to IDLE and clear the counter.
  - Successful load: readdata valid.
  - Store: readdata=0.
  - Error or timeout: readdata=0, buserr=1.
- Latency: an ack sampled on the k-th BUSY cycle gives stall high for k+1 cycles; RESP follows.
- bus_ack/bus_err received in IDLE or RESP are ignored.
- Store byte enables and write data:
  - SB: bus_be = 1 << addr[1:0]; bus_wdata = writedata[7:0] replicated ×4.
  - SH: bus_be = addr[1] ? 1100 : 0011; bus_wdata = writedata[15:0] replicated ×2.
  - SW: bus_be = 1111; bus_wdata = writedata.
- Loads: bus_be=1111. The selected lane is the byte at addr[1:0], or the halfword at addr[1]. B/H are sign-extended from the lane MSB; BU/HU are zero-extended.
- Outside RESP, readdata=0; the datapath only samples it when stall=0.
- misalign and buserr are never sticky.

Test Plan:
- Store word, ack late: SW addr=0x100, writedata=0xDEADBEEF, bus_ack on 3rd BUSY cycle -> bus_addr=0x100, bus_be=1111, bus_we=1, bus_wdata=0xDEADBEEF, stall high 4 cycles, RESP stall=0, buserr=0.
- Byte load, signed and unsigned: LB addr=0x103, bus_rdata=0x80FF1234 -> readdata=0xFFFFFF80. Same access with LBU -> 0x00000080. LH addr=0x102 -> 0xFFFF80FF.
- Halfword store: SH addr=0x102, writedata=0x0000ABCD -> bus_addr=0x100, bus_be=1100, bus_wdata=0xABCDABCD.
- Misaligned and illegal: LW addr=0x102 -> misalign=1 one cycle, bus_req never asserted, stall=0. Load funct3=011 -> same response.
- Timeout and error: TIMEOUT=4, no ack -> bus_req high exactly 4 cycles, then RESP with buserr=1, readdata=0. Ack with bus_err=1 -> buserr=1, readdata=0.
- Reset mid-op: reset driven 0 during BUSY -> bus_req=0 and stall=0 immediately, without a clock edge. After release, a new LW addr=0x200 completes normally.
